multicycle_controller: RTL and testbench

Control unit for the multicycle ARM datapath. It replaces the single-cycle decoder's combinational control with a state machine that issues one datapath step per clock: fetch, decode, address/execute, memory, writeback. It also owns the condition-flag register and the conditional-execution check, and stalls on a memory ready handshake. It sits beside the shared instruction/data memory, the instruction register, the register file and the ALU, and drives all their enables and mux selects.

---
 rtl/multicycle_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle ARM datapath. A ten-state FSM runs one datapath
// step per clock: fetch, decode, address/execute, memory, writeback. The unit
// also holds the NZCV condition-flag register, evaluates the condition field
// for conditional execution, and stalls on the memory ready handshake.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset (state FETCH, Flags 0000)
//   Instr[19:0] in   IR bits [31:12]: Cond[19:16] Op[15:14] Funct[13:8] Rd[3:0]
//   ALUFlags    in   live ALU flags {N,Z,C,V}
//   MemReady    in   memory completes the current access this cycle
//   PCWrite     out  PC enable
//   MemWrite    out  memory write strobe
//   RegWrite    out  register file write enable
//   IRWrite     out  instruction register enable
//   AdrSrc      out  memory address select (0 PC, 1 ALUOut)
//   ALUSrcA     out  ALU A select (0 RD1, 1 PC)
//   ALUSrcB     out  ALU B select (00 RD2, 01 ExtImm, 10 constant 4)
//   ResultSrc   out  result select (00 ALUOut, 01 data reg, 10 ALU result)
//   ImmSrc      out  immediate format, Op passed through
//   RegSrc      out  {STR, branch} register-address selects
//   ALUControl  out  00 ADD, 01 SUB, 10 AND, 11 ORR
//   Flags       out  registered flags {N,Z,C,V}
//   State       out  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic        w_unused_rn;

  logic        w_regw;
  logic        w_memw;
  logic        w_branch;
  logic        w_irw;
  logic        w_fetch_adv;
  logic        w_alu_dec;
  logic [1:0]  w_flagw;
  logic        w_condex;
  logic        w_pcs;

  // ARM condition-code evaluation against {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, res;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: res = z;                      // EQ
      4'b0001: res = ~z;                     // NE
      4'b0010: res = c;                      // CS
      4'b0011: res = ~c;                     // CC
      4'b0100: res = n;                      // MI
      4'b0101: res = ~n;                     // PL
      4'b0110: res = v;                      // VS
      4'b0111: res = ~v;                     // VC
      4'b1000: res = c & ~z;                 // HI
      4'b1001: res = ~(c & ~z);              // LS
      4'b1010: res = (n == v);               // GE
      4'b1011: res = (n != v);               // LT
      4'b1100: res = ~z & (n == v);          // GT
      4'b1101: res = z | (n != v);           // LE
      4'b1110: res = 1'b1;                   // AL
      default: res = 1'b0;                   // 1111: never
    endcase
    return res;
  endfunction

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_funct     = Instr[13:8];
  assign w_rd        = Instr[3:0];
  // Rn is not needed by control; folded into an intentionally unused net.
  assign w_unused_rn = ^Instr[7:4];

  // State register with asynchronous reset to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Flag register: only execute states produce a nonzero FlagW, so writes
  // land exactly on the edge leaving EXECUTER/EXECUTEI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flagw[1] & w_condex) begin
        r_flags[3:2] <= ALUFlags[3:2];
      end
      if (w_flagw[0] & w_condex) begin
        r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state logic and per-state datapath selects.
  always_comb begin
    w_next      = S_FETCH;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    w_irw       = 1'b0;
    w_fetch_adv = 1'b0;
    w_alu_dec   = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_irw       = MemReady;
        w_fetch_adv = MemReady;
        w_next      = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (w_op)
          2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;        // undefined opcode: no side effects
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
        w_next = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        w_alu_dec = 1'b1;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB   = 2'b01;
        w_alu_dec = 1'b1;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;                   // illegal encodings recover
      end
    endcase
  end

  // ALU operation and flag-write decode; only active in execute states.
  // Unsupported commands fall back to ADD and never touch the flags.
  always_comb begin
    ALUControl = 2'b00;
    w_flagw    = 2'b00;
    if (w_alu_dec) begin
      case (w_funct[4:1])
        4'b0100: begin ALUControl = 2'b00; w_flagw = {2{w_funct[0]}};  end
        4'b0010: begin ALUControl = 2'b01; w_flagw = {2{w_funct[0]}};  end
        4'b0000: begin ALUControl = 2'b10; w_flagw = {w_funct[0], 1'b0}; end
        4'b1100: begin ALUControl = 2'b11; w_flagw = {w_funct[0], 1'b0}; end
        default: begin ALUControl = 2'b00; w_flagw = 2'b00; end
      endcase
    end else begin
      ALUControl = 2'b00;
      w_flagw    = 2'b00;
    end
  end

  assign w_condex = cond_check(w_cond, r_flags);
  assign w_pcs    = ((w_rd == 4'hF) & w_regw) | w_branch;

  // Write enables are forced low while reset is held; the state register is
  // already FETCH then, so every select shows its FETCH value.
  assign PCWrite  = ~reset & (w_fetch_adv | (w_pcs & w_condex));
  assign MemWrite = ~reset & w_memw & w_condex & MemReady;
  assign RegWrite = ~reset & w_regw & w_condex;
  assign IRWrite  = ~reset & w_irw;

  assign ImmSrc = w_op;
  assign RegSrc = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
  assign Flags  = r_flags;
  assign State  = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each scenario task walks an
// instruction through the FSM one cycle at a time and compares the packed
// control word {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
// ALUSrcB, ResultSrc, ALUControl, Flags} against hand-derived values.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags, State;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  logic [19:0] obs;
  assign obs = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl, Flags};

  // Control words (without flags): {state, PC/Mem/Reg/IR writes, AdrSrc,
  // ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  localparam logic [15:0] E_FETCH    = {4'd0, 4'b1001, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
  localparam logic [15:0] E_FSTALL   = {4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
  localparam logic [15:0] E_DECODE   = {4'd1, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
  localparam logic [15:0] E_MEMADR   = {4'd2, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMREAD  = {4'd3, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWB    = {4'd4, 4'b0010, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
  localparam logic [15:0] E_MEMWR_NO = {4'd5, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_EXR_ORR  = {4'd6, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11};
  localparam logic [15:0] E_EXI_ADD  = {4'd7, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_EXI_SUB  = {4'd7, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01};
  localparam logic [15:0] E_EXI_AND  = {4'd7, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10};
  localparam logic [15:0] E_ALUWB    = {4'd8, 4'b0010, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_ALUWB_PC = {4'd8, 4'b1010, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_ALUWB_NO = {4'd8, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_BR_T     = {4'd9, 4'b1000, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00};
  localparam logic [15:0] E_BR_N     = {4'd9, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00};

  localparam logic [19:0] I_ADDS   = 20'hE2901;
  localparam logic [19:0] I_ADDSEQ = 20'h02901;
  localparam logic [19:0] I_SUBS   = 20'hE2501;
  localparam logic [19:0] I_EORS   = 20'hE2301;
  localparam logic [19:0] I_ANDS   = 20'hE2101;
  localparam logic [19:0] I_ORRPC  = 20'hE180F;
  localparam logic [19:0] I_ORRS   = 20'hE1901;
  localparam logic [19:0] I_LDR    = 20'hE5912;
  localparam logic [19:0] I_STRNE  = 20'h15812;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_UNDEF  = 20'hEC000;

  task automatic test_reset();
    reset = 1'b1; Instr = 20'h00000; ALUFlags = 4'b0000; MemReady = 1'b1;
    #2;
    nvec++;
    if (obs !== {E_FSTALL, 4'b0000}) begin
      $display("FAIL reset_async: got %h expected %h", obs, {E_FSTALL, 4'b0000}); nfail++;
    end
    @(posedge clk); #1;
    nvec++;
    if (obs !== {E_FSTALL, 4'b0000}) begin
      $display("FAIL reset_held: got %h expected %h", obs, {E_FSTALL, 4'b0000}); nfail++;
    end
    reset = 1'b0;
    #1;
    nvec++;
    if (obs !== {E_FETCH, 4'b0000}) begin
      $display("FAIL reset_release: got %h expected %h", obs, {E_FETCH, 4'b0000}); nfail++;
    end
  endtask

  task automatic test_adds();
    logic [19:0] ins [5];
    logic [3:0]  af  [5];
    logic [19:0] exp [5];
    ins = '{I_ADDS, I_ADDS, I_ADDS, I_ADDS, I_ADDS};
    af  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    exp = '{{E_FETCH, 4'b0000}, {E_DECODE, 4'b0000}, {E_EXI_ADD, 4'b0000},
            {E_ALUWB, 4'b0100}, {E_FETCH, 4'b0100}};
    for (int k = 0; k < 5; k++) begin
      Instr = ins[k]; ALUFlags = af[k]; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL adds[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_beq_taken();
    logic [19:0] exp [4];
    exp = '{{E_FETCH, 4'b0100}, {E_DECODE, 4'b0100}, {E_BR_T, 4'b0100}, {E_FETCH, 4'b0100}};
    for (int k = 0; k < 4; k++) begin
      Instr = I_BEQ; ALUFlags = 4'b1111; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL beq_taken[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
    nvec++;
    if ({RegSrc, ImmSrc} !== 4'b0110) begin
      $display("FAIL beq_regsrc_immsrc: got %b expected 0110", {RegSrc, ImmSrc}); nfail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp [4];
    logic        rdy [4];
    exp = '{{E_FETCH, 4'b0100}, {E_DECODE, 4'b0100}, {E_MEMADR, 4'b0100}, {E_MEMREAD, 4'b0100}};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      Instr = I_LDR; ALUFlags = 4'b0000; MemReady = rdy[k];
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL reset_mid[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
    MemReady = 1'b1;
    reset = 1'b1;
    #1;
    nvec++;
    if (obs !== {E_FSTALL, 4'b0000}) begin
      $display("FAIL reset_mid_assert: got %h expected %h", obs, {E_FSTALL, 4'b0000}); nfail++;
    end
    reset = 1'b0;
    #1;
    nvec++;
    if (obs !== {E_FETCH, 4'b0000}) begin
      $display("FAIL reset_mid_release: got %h expected %h", obs, {E_FETCH, 4'b0000}); nfail++;
    end
  endtask

  task automatic test_beq_not_taken();
    logic [19:0] exp [4];
    exp = '{{E_FETCH, 4'b0000}, {E_DECODE, 4'b0000}, {E_BR_N, 4'b0000}, {E_FETCH, 4'b0000}};
    for (int k = 0; k < 4; k++) begin
      Instr = I_BEQ; ALUFlags = 4'b0100; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL beq_not_taken[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_ldr_stall();
    logic [19:0] exp [10];
    logic        rdy [10];
    exp = '{{E_FSTALL, 4'b0000}, {E_FETCH, 4'b0000}, {E_DECODE, 4'b0000},
            {E_MEMADR, 4'b0000}, {E_MEMREAD, 4'b0000}, {E_MEMREAD, 4'b0000},
            {E_MEMREAD, 4'b0000}, {E_MEMREAD, 4'b0000}, {E_MEMWB, 4'b0000},
            {E_FETCH, 4'b0000}};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 10; k++) begin
      Instr = I_LDR; ALUFlags = 4'b1111; MemReady = rdy[k];
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL ldr_stall[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 9) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_strne();
    logic [19:0] ins [9];
    logic [19:0] exp [9];
    ins = '{I_ADDS, I_ADDS, I_ADDS, I_ADDS, I_STRNE, I_STRNE, I_STRNE, I_STRNE, I_STRNE};
    exp = '{{E_FETCH, 4'b0000}, {E_DECODE, 4'b0000}, {E_EXI_ADD, 4'b0000},
            {E_ALUWB, 4'b0111}, {E_FETCH, 4'b0111}, {E_DECODE, 4'b0111},
            {E_MEMADR, 4'b0111}, {E_MEMWR_NO, 4'b0111}, {E_FETCH, 4'b0111}};
    for (int k = 0; k < 9; k++) begin
      Instr = ins[k]; ALUFlags = 4'b0111; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL strne[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 8) begin @(posedge clk); #1; end
    end
    nvec++;
    if ({RegSrc, ImmSrc} !== 4'b1001) begin
      $display("FAIL str_regsrc_immsrc: got %b expected 1001", {RegSrc, ImmSrc}); nfail++;
    end
  endtask

  task automatic test_orr_pc();
    logic [19:0] ins [9];
    logic [3:0]  af  [9];
    logic [19:0] exp [9];
    ins = '{I_ORRPC, I_ORRPC, I_ORRPC, I_ORRPC, I_ORRS, I_ORRS, I_ORRS, I_ORRS, I_ORRS};
    af  = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    exp = '{{E_FETCH, 4'b0111}, {E_DECODE, 4'b0111}, {E_EXR_ORR, 4'b0111},
            {E_ALUWB_PC, 4'b0111}, {E_FETCH, 4'b0111}, {E_DECODE, 4'b0111},
            {E_EXR_ORR, 4'b0111}, {E_ALUWB, 4'b1011}, {E_FETCH, 4'b1011}};
    for (int k = 0; k < 9; k++) begin
      Instr = ins[k]; ALUFlags = af[k]; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL orr_pc[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 8) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_alu_cmds();
    logic [19:0] ins [17];
    logic [3:0]  af  [17];
    logic [19:0] exp [17];
    ins = '{I_ADDSEQ, I_ADDSEQ, I_ADDSEQ, I_ADDSEQ,
            I_SUBS, I_SUBS, I_SUBS, I_SUBS,
            I_EORS, I_EORS, I_EORS, I_EORS,
            I_ANDS, I_ANDS, I_ANDS, I_ANDS, I_ANDS};
    af  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
            4'b0110, 4'b0110, 4'b0110, 4'b0110,
            4'b1111, 4'b1111, 4'b1111, 4'b1111,
            4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
    exp = '{{E_FETCH, 4'b1011}, {E_DECODE, 4'b1011}, {E_EXI_ADD, 4'b1011}, {E_ALUWB_NO, 4'b1011},
            {E_FETCH, 4'b1011}, {E_DECODE, 4'b1011}, {E_EXI_SUB, 4'b1011}, {E_ALUWB, 4'b0110},
            {E_FETCH, 4'b0110}, {E_DECODE, 4'b0110}, {E_EXI_ADD, 4'b0110}, {E_ALUWB, 4'b0110},
            {E_FETCH, 4'b0110}, {E_DECODE, 4'b0110}, {E_EXI_AND, 4'b0110}, {E_ALUWB, 4'b1110},
            {E_FETCH, 4'b1110}};
    for (int k = 0; k < 17; k++) begin
      Instr = ins[k]; ALUFlags = af[k]; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL alu_cmds[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 16) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_undef();
    logic [19:0] exp [3];
    exp = '{{E_FETCH, 4'b1110}, {E_DECODE, 4'b1110}, {E_FETCH, 4'b1110}};
    for (int k = 0; k < 3; k++) begin
      Instr = I_UNDEF; ALUFlags = 4'b0001; MemReady = 1'b1;
      #1;
      nvec++;
      if (obs !== exp[k]) begin
        $display("FAIL undef[%0d]: got %h expected %h", k, obs, exp[k]); nfail++;
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_beq_taken();
    test_reset_mid();
    test_beq_not_taken();
    test_ldr_stall();
    test_strne();
    test_orr_pc();
    test_alu_cmds();
    test_undef();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
